// File: rtl/lsu_pkg.sv
// Shared types for the warp load/store unit: the operation code and the
// state encodings of the warp-level and per-lane FSMs.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_NOP   = 2'd0,
        LSU_LOAD  = 2'd1,
        LSU_STORE = 2'd2
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } top_state_t;

    typedef enum logic [1:0] {
        L_IDLE,
        L_REQ,
        L_RELEASE,
        L_DONE
    } lane_state_t;

endpackage

// File: rtl/lsu_lane.sv
// One lane of the warp LSU: valid/ready request, release wait for ready
// to fall, and the captured load result.
module lsu_lane
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  enable,
    input  logic                  clear,
    input  lsu_op_t               op,
    output logic                  read_valid,
    input  logic                  read_ready,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  write_valid,
    input  logic                  write_ready,
    output logic                  complete,
    output logic [DATA_WIDTH-1:0] load_data
);

    lane_state_t state;
    lane_state_t state_next;
    logic        ready;

    assign ready = (op == LSU_LOAD) ? read_ready : write_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= L_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        read_valid  = 1'b0;
        write_valid = 1'b0;
        complete    = 1'b0;
        unique case (state)
            L_IDLE: begin
                if (go) state_next = enable ? L_REQ : L_DONE;
            end
            L_REQ: begin
                read_valid  = (op == LSU_LOAD);
                write_valid = (op == LSU_STORE);
                if (ready) state_next = L_RELEASE;
            end
            L_RELEASE: begin
                // Finishing this cycle lets the warp leave ACTIVE one cycle earlier.
                complete = !ready;
                if (!ready) state_next = L_DONE;
            end
            L_DONE: begin
                complete = 1'b1;
                if (clear) state_next = L_IDLE;
            end
            default: state_next = L_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_data <= '0;
        end else if (state == L_REQ && ready && op == LSU_LOAD) begin
            load_data <= read_data;
        end
    end

endmodule

// File: rtl/warp_lsu.sv
// Warp load/store unit: one request per active lane, done after all lanes.
// Define WARP_LSU_STATS_EN to add the stall_cycles counter output.
module warp_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 8,
    parameter int NUM_THREADS   = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  lsu_op_t                                   op,
    input  logic [NUM_THREADS-1:0]                    thread_mask,
    input  logic [NUM_THREADS-1:0][ADDRESS_WIDTH-1:0] lane_address,
    input  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]    lane_store_data,
    output logic                                      busy,
    output logic                                      done,
    output logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]    lane_load_data,
    output logic [NUM_THREADS-1:0]                    mem_read_valid,
    output logic [NUM_THREADS-1:0][ADDRESS_WIDTH-1:0] mem_read_address,
    input  logic [NUM_THREADS-1:0]                    mem_read_ready,
    input  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]    mem_read_data,
    output logic [NUM_THREADS-1:0]                    mem_write_valid,
    output logic [NUM_THREADS-1:0][ADDRESS_WIDTH-1:0] mem_write_address,
    output logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]    mem_write_data,
    input  logic [NUM_THREADS-1:0]                    mem_write_ready
`ifdef WARP_LSU_STATS_EN
    ,
    output logic [31:0]                               stall_cycles
`endif
);

    top_state_t                               state;
    top_state_t                               state_next;
    lsu_op_t                                  op_q;
    logic [NUM_THREADS-1:0][ADDRESS_WIDTH-1:0] address_q;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]    data_q;
    logic [NUM_THREADS-1:0]                   complete;
    logic                                     accept;
    logic                                     issue;
    logic                                     clear;

    assign accept = (state == IDLE) && start;
    assign issue  = accept && (op == LSU_LOAD || op == LSU_STORE)
                    && (|thread_mask);
    assign clear  = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= LSU_NOP;
            address_q <= '0;
            data_q    <= '0;
        end else begin
            state <= state_next;
            if (issue) begin
                op_q      <= op;
                address_q <= lane_address;
                data_q    <= lane_store_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_next = issue ? ACTIVE : DONE;
            end
            ACTIVE: begin
                busy = 1'b1;
                if (&complete) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_read_address  = address_q;
    assign mem_write_address = address_q;
    assign mem_write_data    = data_q;

    for (genvar i = 0; i < NUM_THREADS; i++) begin : g_lane
        lsu_lane #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .go          (issue),
            .enable      (thread_mask[i]),
            .clear       (clear),
            .op          (op_q),
            .read_valid  (mem_read_valid[i]),
            .read_ready  (mem_read_ready[i]),
            .read_data   (mem_read_data[i]),
            .write_valid (mem_write_valid[i]),
            .write_ready (mem_write_ready[i]),
            .complete    (complete[i]),
            .load_data   (lane_load_data[i])
        );
    end

`ifdef WARP_LSU_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (state == ACTIVE && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_warp_lsu.sv
// Randomized bench for warp_lsu with a transaction-level model and a
// reactive memory controller model.
module tb_warp_lsu;
    import lsu_pkg::*;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int NT = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   start = 1'b0;
    lsu_op_t                op = LSU_NOP;
    logic [NT-1:0]          thread_mask = '0;
    logic [NT-1:0][AW-1:0]  lane_address = '0;
    logic [NT-1:0][DW-1:0]  lane_store_data = '0;
    logic                   busy;
    logic                   done;
    logic [NT-1:0][DW-1:0]  lane_load_data;
    logic [NT-1:0]          mem_read_valid;
    logic [NT-1:0][AW-1:0]  mem_read_address;
    logic [NT-1:0]          mem_read_ready = '0;
    logic [NT-1:0][DW-1:0]  mem_read_data = '0;
    logic [NT-1:0]          mem_write_valid;
    logic [NT-1:0][AW-1:0]  mem_write_address;
    logic [NT-1:0][DW-1:0]  mem_write_data;
    logic [NT-1:0]          mem_write_ready = '0;
`ifdef WARP_LSU_STATS_EN
    logic [31:0]            stall_cycles;
`endif

    warp_lsu #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .NUM_THREADS   (NT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .op                (op),
        .thread_mask       (thread_mask),
        .lane_address      (lane_address),
        .lane_store_data   (lane_store_data),
        .busy              (busy),
        .done              (done),
        .lane_load_data    (lane_load_data),
        .mem_read_valid    (mem_read_valid),
        .mem_read_address  (mem_read_address),
        .mem_read_ready    (mem_read_ready),
        .mem_read_data     (mem_read_data),
        .mem_write_valid   (mem_write_valid),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write_ready   (mem_write_ready)
`ifdef WARP_LSU_STATS_EN
        ,
        .stall_cycles      (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [256];

    // Transaction model: start cycle, predicted done cycle, abort cycle.
    int                    m_c = -100;
    int                    m_done = -100;
    int                    m_kill = 0;
    lsu_op_t               m_op = LSU_NOP;
    logic [NT-1:0]         m_mask = '0;
    logic [NT-1:0][AW-1:0] m_addr = '0;
    logic [NT-1:0][DW-1:0] m_data = '0;
    int                    m_delay [NT] = '{1, 1, 1, 1};
    int                    m_sticky [NT] = '{0, 0, 0, 0};
    logic [NT-1:0][DW-1:0] exp_lld = '0;
    int                    lld_from = 0;
    longint                exp_stall = 0;
    int                    vectors = 0;
    int                    miscompares = 0;
    bit                    checking = 1'b0;

    int vcnt [NT];
    int tail [NT];
    bit [NT-1:0] rdy = '0;
    bit [NT-1:0] is_wr = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    int  t;
    bit  eb, ed, erv, ewv;

    always @(negedge clk) begin
        t  = cyc;
        eb = (t > m_c) && (t < m_kill) && (t < m_done);
        ed = (t > m_c) && (t < m_kill) && (t == m_done);
        if (checking) begin
            chk("busy", busy, eb);
            chk("done", done, ed);
            for (int i = 0; i < NT; i++) begin
                erv = (t > m_c) && (t < m_kill) && m_mask[i] && m_op == LSU_LOAD
                      && (t <= m_c + 1 + m_delay[i]);
                ewv = (t > m_c) && (t < m_kill) && m_mask[i] && m_op == LSU_STORE
                      && (t <= m_c + 1 + m_delay[i]);
                chk($sformatf("read_valid[%0d]", i), mem_read_valid[i], erv);
                chk($sformatf("write_valid[%0d]", i), mem_write_valid[i], ewv);
                if (erv) chk($sformatf("read_address[%0d]", i), mem_read_address[i], m_addr[i]);
                if (ewv) begin
                    chk($sformatf("write_address[%0d]", i), mem_write_address[i], m_addr[i]);
                    chk($sformatf("write_data[%0d]", i), mem_write_data[i], m_data[i]);
                end
            end
            if (t >= lld_from) chk("lane_load_data", lane_load_data, exp_lld);
`ifdef WARP_LSU_STATS_EN
            chk("stall_cycles", stall_cycles, exp_stall);
`endif
        end
        if (reset) exp_stall = 0;
        else if (eb) exp_stall++;

        // Controller model: ready after m_delay valid cycles, held
        // 1+m_sticky cycles after valid falls.
        for (int i = 0; i < NT; i++) begin
            if (reset) begin
                vcnt[i] = 0;
                tail[i] = 0;
                rdy[i]  = 1'b0;
            end else if (mem_read_valid[i] || mem_write_valid[i]) begin
                vcnt[i]++;
                is_wr[i] = mem_write_valid[i];
                if (vcnt[i] >= m_delay[i] + 1) begin
                    if (!rdy[i] && is_wr[i]) mem[mem_write_address[i]] = mem_write_data[i];
                    rdy[i]  = 1'b1;
                    tail[i] = 1 + m_sticky[i];
                end else begin
                    rdy[i] = 1'b0;
                end
            end else begin
                vcnt[i] = 0;
                if (tail[i] > 0) begin
                    rdy[i] = 1'b1;
                    tail[i]--;
                end else begin
                    rdy[i] = 1'b0;
                end
            end
            mem_read_ready[i]  = rdy[i] && !is_wr[i];
            mem_write_ready[i] = rdy[i] && is_wr[i];
            mem_read_data[i]   = (rdy[i] && !is_wr[i] && mem_read_valid[i])
                                 ? mem[mem_read_address[i]] : DW'($urandom);
        end
    end

    // All driver tasks are entered 2 time units after a rising edge.
    task automatic begin_op(input lsu_op_t o, input logic [NT-1:0] mk,
                            input logic [NT-1:0][AW-1:0] a,
                            input logic [NT-1:0][DW-1:0] d,
                            input int dly [NT], input int stk [NT]);
        int mx;
        op = o;
        thread_mask = mk;
        lane_address = a;
        lane_store_data = d;
        start = 1'b1;
        m_c = cyc;
        m_op = o;
        m_mask = mk;
        m_addr = a;
        m_data = d;
        m_delay = dly;
        m_sticky = stk;
        m_kill = 1 << 30;
        if ((o == LSU_LOAD || o == LSU_STORE) && mk != '0) begin
            mx = 0;
            for (int i = 0; i < NT; i++)
                if (mk[i] && dly[i] + stk[i] > mx) mx = dly[i] + stk[i];
            m_done = cyc + 4 + mx;
        end else begin
            m_done = cyc + 1;
        end
        if (o == LSU_LOAD)
            for (int i = 0; i < NT; i++)
                if (mk[i]) exp_lld[i] = mem[a[i]];
        lld_from = m_done;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        m_kill = cyc + 1;
        exp_lld = '0;
        lld_from = cyc + 1;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic run_op(input lsu_op_t o, input logic [NT-1:0] mk,
                          input logic [NT-1:0][AW-1:0] a,
                          input logic [NT-1:0][DW-1:0] d,
                          input int dly [NT], input int stk [NT],
                          input bit inject, output int lat);
        int  c;
        bit  got;
        begin_op(o, mk, a, d, dly, stk);
        c = cyc;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
            start = inject && (cyc == c + 2) && (m_done >= c + 3);
            if (start) begin
                op = lsu_op_t'($urandom_range(1, 2));
                thread_mask = NT'($urandom);
                lane_address = {NT{8'h5A}};
            end
        end
        lat = cyc - c;
        @(posedge clk);
        #2;
        start = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout got=none expected=%0d", m_done - c);
            lat = -1;
            do_reset();
        end
    endtask

    int lat;
    int dl [NT];
    int sk [NT];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < NT; i++) begin
            vcnt[i] = 0;
            tail[i] = 0;
        end
        @(posedge clk);
        #2;
        checking = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_load_data", lane_load_data, 64'h0);

        // Load on all lanes, ready one cycle after valid.
        for (int i = 0; i < NT; i++) mem[8'h10 + i] = DW'(16'h00A0 + i);
        run_op(LSU_LOAD, 4'b1111, {8'h13, 8'h12, 8'h11, 8'h10}, '0,
               '{1, 1, 1, 1}, '{0, 0, 0, 0}, 1'b0, lat);
        chk("load_latency", lat, 5);
        chk("load_result", lane_load_data, 64'h00A3_00A2_00A1_00A0);

        // Store on lanes 0 and 2 only.
        for (int i = 0; i < NT; i++) mem[i] = DW'(16'hEEE0 + i);
        run_op(LSU_STORE, 4'b0101, {8'h03, 8'h02, 8'h01, 8'h00},
               {16'h4444, 16'h3333, 16'h2222, 16'h1111},
               '{1, 1, 1, 1}, '{0, 0, 0, 0}, 1'b0, lat);
        chk("store_latency", lat, 5);
        chk("store_mem0", mem[0], 16'h1111);
        chk("store_mem1", mem[1], 16'hEEE1);
        chk("store_mem2", mem[2], 16'h3333);
        chk("store_mem3", mem[3], 16'hEEE3);

        // Staggered ready, with a start pulse while busy.
        run_op(LSU_LOAD, 4'b1111, {8'h23, 8'h22, 8'h21, 8'h20}, '0,
               '{9, 2, 2, 1}, '{0, 0, 0, 0}, 1'b1, lat);
        chk("stagger_latency", lat, 13);

        // Ready held three extra cycles on lane 3.
        run_op(LSU_STORE, 4'b1111, {8'h33, 8'h32, 8'h31, 8'h30}, {4{16'hBEEF}},
               '{1, 1, 1, 1}, '{0, 0, 0, 3}, 1'b0, lat);
        chk("sticky_latency", lat, 8);

        run_op(LSU_NOP, 4'b1111, '0, '0, '{1, 1, 1, 1}, '{0, 0, 0, 0}, 1'b0, lat);
        chk("nop_latency", lat, 1);
        run_op(LSU_LOAD, 4'b0000, '0, '0, '{1, 1, 1, 1}, '{0, 0, 0, 0}, 1'b0, lat);
        chk("mask0_latency", lat, 1);

        // Reset while two lanes are requesting.
        begin_op(LSU_LOAD, 4'b0011, {8'h43, 8'h42, 8'h41, 8'h40}, '0,
                 '{5, 5, 5, 5}, '{0, 0, 0, 0});
        @(posedge clk);
        #2;
        start = 1'b0;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        do_reset();
        chk("reset_mid_valid", mem_read_valid, 0);
        chk("reset_mid_busy", busy, 0);
`ifdef WARP_LSU_STATS_EN
        chk("reset_mid_stall", stall_cycles, 0);
`endif
        repeat (3) @(posedge clk);
        #2;
        run_op(LSU_LOAD, 4'b1111, {8'h13, 8'h12, 8'h11, 8'h10}, '0,
               '{1, 1, 1, 1}, '{0, 0, 0, 0}, 1'b0, lat);
        chk("post_reset_latency", lat, 5);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NT; i++) begin
                dl[i] = $urandom_range(1, 4);
                sk[i] = $urandom_range(0, 2);
            end
            run_op(($urandom_range(0, 9) == 0) ? LSU_NOP
                   : lsu_op_t'($urandom_range(1, 2)),
                   NT'($urandom), {NT{AW'($urandom)}} ^ AW*NT'($urandom),
                   {$urandom, $urandom}, dl, sk, 1'($urandom), lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/warp_lsu.md
Name: warp_lsu

Overview:
- Per-warp load/store unit that turns one warp memory instruction into one memory request per active lane.
- Presents NUM_THREADS consumer ports on the data-memory controller's consumer interface.
- Sits between the warp execution/scheduler stage (upstream) and the data memory controller (downstream).
- Issues all active lanes concurrently, collects every lane's completion, then pulses done with load results.

Parameters:
- DATA_WIDTH, 16, data word width.
- ADDRESS_WIDTH, 8, memory address width.
- NUM_THREADS, 4, lanes per warp; equals the number of controller consumers this unit drives.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin an operation; sampled only in IDLE.
- op  in  lsu_op_t (2)  LSU_NOP / LSU_LOAD / LSU_STORE; sampled with start.
- thread_mask  in  NUM_THREADS  active lanes; sampled with start.
- lane_address  in  ADDRESS_WIDTH x NUM_THREADS  per-lane address; sampled with start.
- lane_store_data  in  DATA_WIDTH x NUM_THREADS  per-lane store data; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- lane_load_data  out  DATA_WIDTH x NUM_THREADS  load results; valid from done until the next accepted start.
- mem_read_valid / mem_read_address  out  NUM_THREADS / ADDRESS_WIDTH x NUM_THREADS  consumer read request.
- mem_read_ready / mem_read_data  in  NUM_THREADS / DATA_WIDTH x NUM_THREADS  controller read response.
- mem_write_valid / mem_write_address / mem_write_data  out  consumer write request.
- mem_write_ready  in  NUM_THREADS  controller write response.

Behaviour:
- Reset: all outputs 0, lane_load_data 0, all lane FSMs in L_IDLE, top FSM in IDLE. Reset mid-operation drops every valid in the next cycle; the in-flight transaction is abandoned.
- Top FSM states: IDLE, ACTIVE, DONE.
- IDLE to ACTIVE on start with op LOAD or STORE. Latch op, mask, addresses and store data. busy=1 next cycle.
- start with op NOP, or with mask==0, goes IDLE to DONE: done pulses exactly one cycle later, with no requests issued.
- start outside IDLE is ignored.
- Lane FSM states: L_IDLE, L_REQ, L_RELEASE, L_DONE.
- On accept, masked-on lanes enter L_REQ. Their valid (read or write per op) rises the cycle after start, with address and data held stable.
- Masked-off lanes go straight to L_DONE and never assert valid.
- L_REQ: on the cycle ready is seen high, capture mem_read_data (LOAD) into lane_load_data[i], drop valid (registered, next edge), go to L_RELEASE.
- L_RELEASE: wait for ready low (the controller drops ready one cycle after valid falls), then go to L_DONE. The lane never re-raises valid while ready is still high.
- ACTIVE to DONE on the cycle all lanes are in L_DONE. DONE drives done=1 and busy=0 for one cycle, returns all lanes to L_IDLE, and goes to IDLE.
- Minimum latency start→done, with ready returning the cycle after valid: 5 cycles.
- Lanes complete in any order. Stored data for non-masked lanes is never sent.
- lane_load_data for masked-off lanes keeps its previous value.
- ready arriving for a lane that is not in L_REQ is ignored.

Optional Feature:
- Macro: WARP_LSU_STATS_EN.
- Defined: adds output stall_cycles (32 bits), which counts ACTIVE cycles. It clears on reset, saturates at all-ones, and is not cleared between operations.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- lsu_pkg holds lsu_op_t (LSU_NOP=0, LSU_LOAD=1, LSU_STORE=2), the top-state enum and the lane-state enum.
- Sub-module lsu_lane: one lane's request/release handshake FSM plus result register, generated NUM_THREADS times. warp_lsu holds the top FSM, the latch, and the all-done reduction.

Test Plan:
- Load, all lanes, ready one cycle after valid: mask=4'b1111, addrs 0x10..0x13, memory returns 0xA0..0xA3 → done exactly 5 cycles after start, lane_load_data={0xA3,0xA2,0xA1,0xA0}.
- Store, mask=4'b0101, data 0x1111/0x2222/0x3333/0x4444 → write_valid only on lanes 0 and 2, memory holds 0x1111@addr0 and 0x3333@addr2, lanes 1 and 3 never assert valid.
- Staggered ready: lane 3 ready after 1 cycle, lane 0 after 9 cycles → done only after lane 0 completes, and lane 3 valid stays low after release.
- Sticky ready: ready held high 3 extra cycles after valid falls → lane does not re-request; done waits until ready is low.
- mask=0 or op=NOP → done one cycle after start, busy never asserted, no valids. A start pulse issued while busy is ignored (no second done).
- Reset asserted while 2 lanes are in L_REQ → next cycle all valids=0, busy=0, done=0. A later start works normally. With WARP_LSU_STATS_EN, stall_cycles=0 after reset.
